step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//   Parametrised multi-channel step sequencer for the synth note path. Replaces
//   the fixed 16-step note-trigger decoder with an internal tempo divider and
//   step counter. Also adds per-channel writable step patterns and one-cycle
//   trigger pulses. Sits between the control/UI logic and the voice envelope
//   generators.
// PARAMETERS
//   STEPS     16  steps per pattern (2..64); STEP_W = $clog2(STEPS)
//   CHANNELS  4   independent trigger channels (1..16); CH_W = max(1,$clog2(CHANNELS))
//   DIV_W     16  width of the clocks-per-step divider value
// PORTS
//   clk          in   1         system clock, all logic on rising edge
//   reset        in   1         synchronous, active-high reset
//   run          in   1         level; 1 = sequencer running, 0 = stopped
//   tick_div     in   DIV_W     clocks per step; 0 treated as 1
//   pat_we       in   1         pattern write strobe
//   pat_ch       in   CH_W      channel index for pattern write
//   pat_data     in   STEPS     new pattern, bit n = fire on step n
//   step         out  STEP_W    current step index
//   step_onehot  out  STEPS     one-hot decode of step (all 0 when stopped)
//   step_stb     out  1         1-cycle pulse when a step begins
//   trig         out  CHANNELS  1-cycle pulse per channel whose pattern bit is set
//   running      out  1         1 while in RUN state
// BEHAVIOUR
//   Reset: step=0, step_onehot=0, step_stb=0, trig=0, running=0, divider=0,
//   all patterns cleared to 0, FSM=IDLE. Reset has priority over every input,
//   including mid-step.
//   FSM:
//   - IDLE: run=1 sampled at edge k -> RUN. At edge k+1: step=0, step_stb=1,
//     trig=pattern[*][0]. Latency is 1 cycle from run sampled to first strobe.
//   - RUN: run=0 sampled -> IDLE at the next edge. step=0, step_onehot=0,
//     divider cleared, no further strobes. Any pending step is discarded.
//   Divider: latched div = max(tick_div,1) at each step start. The counter counts
//   0..div-1, and the next step starts div cycles after the previous strobe.
//   Changes to tick_div apply only at the next step boundary.
//   Step wrap: STEPS-1 -> 0 with no gap cycle; a strobe fires on step 0 again.
//   Trigger: trig[c] = step_stb & pattern[c][step], registered with step_stb.
//   It is never high outside a strobe cycle.
//   Pattern write: takes effect at the edge after pat_we.
//   - Write on the same edge a strobe is generated: the strobe uses the OLD
//     pattern.
//   - pat_ch >= CHANNELS: the write is ignored.
//   - Writes are accepted in both IDLE and RUN.
//   div=1 edge case: step_stb is high every cycle and step increments every cycle.
// CONFIGURATION
//   SEQ_GATE_EN defined: adds input gate_len [DIV_W-1:0] and output
//   gate [CHANNELS-1:0].
//   - gate[c] rises with trig[c] and stays high for g cycles, where
//     g = clamp(gate_len,1,div) is latched at trigger time.
//   - A retrigger restarts the count.
//   - The gate clears on reset or on a RUN->IDLE transition.
//   SEQ_GATE_EN undefined: gate_len and gate ports are absent and there is no
//   gate logic. All other behaviour is identical.
// TESTING
//   1 reset: hold reset 3 cycles with run=1 -> all outputs 0, patterns read
//     back 0 (no trig over 2 full loops).
//   2 basic: ch0=16'h0001, ch1=16'h8000, tick_div=4, run=1 -> step_stb every
//     4 cycles. trig[0] on step 0, trig[1] on step 15, then wrap to step 0.
//   3 tick_div=0 and tick_div=1 -> step advances every cycle and step_onehot
//     walks 1,2,4..; tick_div changed mid-step -> old period completes first.
//   4 write collision: pat_we to ch2 (bits all 1) on the step-3 strobe edge ->
//     no trig[2] on step 3, trig[2] on step 4; pat_ch=CHANNELS -> no change.
//   5 stop/restart: run=0 at step 7 -> IDLE next edge, step=0, no strobes.
//     run=1 -> strobe on step 0 one cycle later. Reset asserted mid-step ->
//     immediate IDLE.
//   6 SEQ_GATE_EN: tick_div=8, gate_len=3 -> gate high 3 cycles per trig.
//     gate_len=20 -> clamped to 8. gate_len=0 -> 1 cycle.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: tempo-divided multi-channel step sequencer with writable per-channel patterns
// Ports: clk, reset (sync, active-high), run (level), tick_div (clocks per step, 0 acts as 1),
//   pat_we/pat_ch/pat_data (pattern write, out-of-range channel ignored), step, step_onehot,
//   step_stb (1-cycle step start pulse), trig (per-channel pulse on pattern hit), running.
// Optional SEQ_GATE_EN: adds gate_len input and gate output (per-channel gate of clamp(gate_len,1,div) cycles).
module step_sequencer #(
  parameter int STEPS = 16,
  parameter int CHANNELS = 4,
  parameter int DIV_W = 16,
  localparam int STEP_W = $clog2(STEPS),
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [DIV_W-1:0]    tick_div,
  input  logic                pat_we,
  input  logic [CH_W-1:0]     pat_ch,
  input  logic [STEPS-1:0]    pat_data,
`ifdef SEQ_GATE_EN
  input  logic [DIV_W-1:0]    gate_len,
  output logic [CHANNELS-1:0] gate,
`endif
  output logic [STEP_W-1:0]   step,
  output logic [STEPS-1:0]    step_onehot,
  output logic                step_stb,
  output logic [CHANNELS-1:0] trig,
  output logic                running
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [STEPS-1:0] pattern [CHANNELS];
  logic [DIV_W-1:0] cnt, div_q, div_n;
  logic [STEP_W-1:0] step_n;
  logic [CHANNELS-1:0] trig_n;
  logic armed, fire, wr_ok;
  // armed marks the first step after entering RUN, which must land on step 0 one cycle later
  always_comb begin
    state_n = run ? RUN : IDLE;
    fire = state == RUN && run && (armed || cnt == div_q - DIV_W'(1));
    div_n = tick_div == '0 ? DIV_W'(1) : tick_div;
    step_n = armed || step == STEP_W'(STEPS - 1) ? '0 : step + STEP_W'(1);
    trig_n = '0;
    for (int c = 0; c < CHANNELS; c++) trig_n[c] = pattern[c][step_n];
  end
  assign wr_ok = pat_we && {1'b0, pat_ch} < (CH_W + 1)'(CHANNELS);
  assign running = state == RUN;
  assign step_onehot = running ? STEPS'(1) << step : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step <= '0;
      cnt <= '0;
      div_q <= '0;
      armed <= 1'b1;
      step_stb <= 1'b0;
      trig <= '0;
      for (int c = 0; c < CHANNELS; c++) pattern[c] <= '0;
    end else begin
      state <= state_n;
      step_stb <= fire;
      trig <= fire ? trig_n : '0;
      if (wr_ok) pattern[pat_ch] <= pat_data;
      if (state_n == IDLE) begin
        step <= '0;
        cnt <= '0;
        div_q <= '0;
        armed <= 1'b1;
      end else if (fire) begin
        step <= step_n;
        cnt <= '0;
        div_q <= div_n;
        armed <= 1'b0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end
`ifdef SEQ_GATE_EN
  logic [DIV_W-1:0] rem [CHANNELS];
  logic [DIV_W-1:0] g_n;
  // gate length is clamped against the period latched by the same strobe
  assign g_n = gate_len == '0 ? DIV_W'(1) : gate_len > div_n ? div_n : gate_len;
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      rem[c] <= reset || state_n == IDLE ? '0 : fire && trig_n[c] ? g_n : rem[c] != '0 ? rem[c] - DIV_W'(1) : '0;
  end
  always_comb begin
    gate = '0;
    for (int c = 0; c < CHANNELS; c++) gate[c] = rem[c] != '0;
  end
`endif
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed and random stimulus against an event-scheduled reference model
module tb_step_sequencer;
  localparam int ST = 16;
  localparam int CH = 3;
  localparam int DW = 16;
  localparam int SW = 4;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic [DW-1:0] tick_div = 1;
  logic pat_we = 1'b0;
  logic [CW-1:0] pat_ch = '0;
  logic [ST-1:0] pat_data = '0;
  logic [SW-1:0] step;
  logic [ST-1:0] step_onehot;
  logic step_stb;
  logic [CH-1:0] trig;
  logic running;
`ifdef SEQ_GATE_EN
  logic [DW-1:0] gate_len = '0;
  logic [CH-1:0] gate;
`endif
  int total = 0;
  int bad = 0;
  int cyc = 0;
  // model: absolute edge index of the next strobe rather than a running counter
  bit m_run = 0;
  bit m_first = 0;
  int m_step = 0;
  int m_next = 0;
  logic [ST-1:0] m_pat [CH];
  int m_gu [CH];
  logic seen;
  bit found;
  step_sequencer #(.STEPS(ST), .CHANNELS(CH), .DIV_W(DW)) dut (
    .clk(clk), .reset(reset), .run(run), .tick_div(tick_div),
    .pat_we(pat_we), .pat_ch(pat_ch), .pat_data(pat_data),
`ifdef SEQ_GATE_EN
    .gate_len(gate_len), .gate(gate),
`endif
    .step(step), .step_onehot(step_onehot), .step_stb(step_stb),
    .trig(trig), .running(running)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [CH-1:0] et;
    logic es;
    int d;
    et = '0;
    es = 1'b0;
    if (reset) begin
      m_run = 0;
      m_first = 0;
      m_step = 0;
      for (int c = 0; c < CH; c++) begin
        m_pat[c] = '0;
        m_gu[c] = 0;
      end
    end else begin
      if (!m_run) begin
        if (run) begin
          m_run = 1;
          m_first = 1;
          m_next = cyc + 1;
        end
      end else if (!run) begin
        m_run = 0;
        m_step = 0;
        for (int c = 0; c < CH; c++) m_gu[c] = 0;
      end else if (cyc == m_next) begin
        d = tick_div == 0 ? 1 : int'(tick_div);
        m_step = m_first ? 0 : (m_step + 1) % ST;
        m_first = 0;
        m_next = cyc + d;
        es = 1'b1;
        for (int c = 0; c < CH; c++) begin
          et[c] = m_pat[c][m_step];
`ifdef SEQ_GATE_EN
          if (et[c]) m_gu[c] = cyc + (gate_len == 0 ? 1 : int'(gate_len) > d ? d : int'(gate_len));
`endif
        end
      end
      if (pat_we && int'(pat_ch) < CH) m_pat[pat_ch] = pat_data;
    end
    @(posedge clk);
    #1;
    chk("step", 64'(step), 64'(m_step));
    chk("onehot", 64'(step_onehot), m_run ? 64'(1) << m_step : 64'(0));
    chk("stb", 64'(step_stb), 64'(es));
    chk("trig", 64'(trig), 64'(et));
    chk("running", 64'(running), 64'(m_run));
`ifdef SEQ_GATE_EN
    for (int c = 0; c < CH; c++) chk("gate", 64'(gate[c]), 64'(cyc < m_gu[c]));
`endif
    cyc++;
  endtask
  initial begin
    for (int c = 0; c < CH; c++) begin
      m_pat[c] = '0;
      m_gu[c] = 0;
    end
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < CH; c++) begin
      pat_we = 1'b1;
      pat_ch = CW'(c);
      pat_data = ST'($urandom) | ST'(1);
      tick();
    end
    pat_we = 1'b0;
    run = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_running", 64'(running), 64'(0));
    reset = 1'b0;
    tick_div = 1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | (|trig);
    end
    chk("reset_clears_pat", 64'(seen), 64'(0));
    run = 1'b0;
    tick();
    pat_we = 1'b1;
    pat_ch = 0;
    pat_data = 16'h0001;
    tick();
    pat_ch = 1;
    pat_data = 16'h8000;
    tick();
    pat_we = 1'b0;
    tick_div = 4;
    run = 1'b1;
    repeat (132) tick();
    tick_div = 0;
    repeat (20) tick();
    tick_div = 1;
    repeat (20) tick();
    tick_div = 6;
    repeat (3) tick();
    tick_div = 2;
    repeat (30) tick();
    tick_div = 3;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && run && cyc == m_next && !m_first && m_step == 2) found = 1;
      else tick();
    end
    chk("find_step3", 64'(found), 64'(1));
    pat_we = 1'b1;
    pat_ch = 2;
    pat_data = '1;
    tick();
    pat_we = 1'b0;
    chk("coll_step", 64'(step), 64'(3));
    chk("coll_old_pat", 64'(trig[2]), 64'(0));
    repeat (3) tick();
    chk("coll_step4", 64'(step), 64'(4));
    chk("coll_new_pat", 64'(trig[2]), 64'(1));
    pat_we = 1'b1;
    pat_ch = 2'(CH);
    pat_data = '1;
    tick();
    pat_we = 1'b0;
    repeat (60) tick();
    tick_div = 2;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_run && !m_first && m_step == 7) found = 1;
      else tick();
    end
    chk("find_step7", 64'(found), 64'(1));
    run = 1'b0;
    tick();
    chk("stop_running", 64'(running), 64'(0));
    chk("stop_step", 64'(step), 64'(0));
    chk("stop_onehot", 64'(step_onehot), 64'(0));
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | step_stb;
    end
    chk("idle_no_stb", 64'(seen), 64'(0));
    run = 1'b1;
    tick();
    chk("restart_arm_stb", 64'(step_stb), 64'(0));
    chk("restart_running", 64'(running), 64'(1));
    tick();
    chk("restart_stb", 64'(step_stb), 64'(1));
    chk("restart_step", 64'(step), 64'(0));
    tick_div = 5;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    chk("midreset_running", 64'(running), 64'(0));
    chk("midreset_step", 64'(step), 64'(0));
    reset = 1'b0;
    tick();
`ifdef SEQ_GATE_EN
    pat_we = 1'b1;
    pat_ch = 0;
    pat_data = '1;
    tick();
    pat_we = 1'b0;
    tick_div = 8;
    gate_len = 3;
    repeat (40) tick();
    gate_len = 20;
    repeat (40) tick();
    gate_len = 0;
    repeat (40) tick();
`endif
    run = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      reset = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 31) == 0) run = ~run;
      if ($urandom_range(0, 15) == 0) tick_div = DW'($urandom_range(0, 5));
      pat_we = $urandom_range(0, 7) == 0;
      pat_ch = CW'($urandom_range(0, 3));
      pat_data = ST'($urandom);
`ifdef SEQ_GATE_EN
      gate_len = DW'($urandom_range(0, 10));
`endif
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
